// File: rtl/lix_pkg.sv
// Shared constants for the lix masked A2B pipeline (CSA top and stage sequencer).
package lix_pkg;

    localparam int LIX_STAGES = 4;
    localparam int LIX_CNT_W  = 16;

endpackage

// File: rtl/lix_stage_ctl.sv
// One pipeline stage: decides whether the stage register loads this cycle and
// tracks whether the stage currently holds a word.
module lix_stage_ctl (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_src,
    input  logic i_drain,
    input  logic i_rnd_vld,
    input  logic i_flush,
    output logic o_en,
    output logic o_hold,
    output logic o_vld
);

    logic r_vld;

    // A stage is stuck only if it is occupied and its word is not leaving.
    assign o_hold = r_vld & ~i_drain;
    assign o_en   = i_src & ~o_hold & i_rnd_vld & ~i_flush;
    assign o_vld  = r_vld;

    // NOTE: state flops use non-blocking assignments so every stage samples the
    // pre-edge values of its neighbours, regardless of evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= 1'b0;
        end else if (o_en) begin
            r_vld <= 1'b1;
        end else if (i_drain || i_flush) begin
            r_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/lix_pipe_ctrl.sv
// Stage-enable sequencer for the masked A2B pipeline: per-stage valid tracking,
// upstream/downstream handshake, randomness stall, flush and a transfer counter.
module lix_pipe_ctrl
    import lix_pkg::*;
#(
    parameter int S  = LIX_STAGES,
    parameter int CW = LIX_CNT_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_vld,
    output logic          o_rdy,
    input  logic          i_rdy,
    output logic          o_vld,
    input  logic          i_rnd_vld,
    output logic          o_rnd_take,
    input  logic          i_flush,
    output logic [S-1:0]  o_stg_en,
    output logic [S-1:0]  o_stg_vld,
    output logic          o_busy,
    output logic [CW-1:0] o_cnt
);

    logic [S-1:0]  w_vld;
    logic [S-1:0]  w_en;
    logic          w_hold0;
    logic          w_xfer;
    logic [CW-1:0] r_cnt;

    // The drain of stage k is the enable of stage k+1, so enables ripple from
    // the output stage back towards the input.
    for (genvar k = 0; k < S; k++) begin : g_stage
        logic w_src;
        logic w_drain;
        logic w_stage_en;
        logic w_hold;

        if (k == 0) begin : g_first
            assign w_src   = i_vld;
            assign w_hold0 = w_hold;
        end else begin : g_mid
            assign w_src = w_vld[k-1];
        end

        if (k == S - 1) begin : g_last
            assign w_drain = i_rdy;
        end else begin : g_inner
            assign w_drain = g_stage[k+1].w_stage_en;
        end

        lix_stage_ctl u_ctl (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .i_src     (w_src),
            .i_drain   (w_drain),
            .i_rnd_vld (i_rnd_vld),
            .i_flush   (i_flush),
            .o_en      (w_stage_en),
            .o_hold    (w_hold),
            .o_vld     (w_vld[k])
        );

        assign w_en[k] = w_stage_en;
    end

    // The output word leaves on i_rdy alone; it needs no randomness and a
    // flush does not cancel it.
    assign w_xfer = w_vld[S-1] & i_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_rdy      = ~w_hold0 & i_rnd_vld & ~i_flush;
    assign o_vld      = w_vld[S-1];
    assign o_rnd_take = |w_en;
    assign o_stg_en   = w_en;
    assign o_stg_vld  = w_vld;
    assign o_busy     = |w_vld;
    assign o_cnt      = r_cnt;

endmodule

// File: doc/lix_pipe_ctrl.md
# lix_pipe_ctrl

Stage-enable sequencer for the masked A2B conversion pipeline built from `lix_reg` data stages. It tracks one valid bit per pipeline stage and drives each stage register's load enable. It applies a valid/ready handshake at the upstream and downstream ends, and stalls every stage load while fresh mask randomness is unavailable. It sits beside the CSA datapath; the datapath registers take `o_stg_en[k]` on their enable input and tie their valid input high.

## Interface
- `S`, 4: number of pipeline stages (≥2).
- `CW`, 16: width of the completed-transaction counter.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset: asynchronous, active-low.
- `i_vld`  in  1  upstream data valid.
- `o_rdy`  out  1  upstream ready; a transfer happens when `i_vld & o_rdy`.
- `i_rdy`  in  1  downstream ready.
- `o_vld`  out  1  downstream data valid (stage S-1 occupied).
- `i_rnd_vld`  in  1  fresh randomness available this cycle.
- `o_rnd_take`  out  1  randomness consumed this cycle (any stage loads).
- `i_flush`  in  1  synchronous pipeline flush.
- `o_stg_en`  out  S  per-stage load enable for the datapath `lix_reg`.
- `o_stg_vld`  out  S  per-stage occupancy.
- `o_busy`  out  1  any stage occupied.
- `o_cnt`  out  CW  count of completed downstream transfers, wraps modulo 2^CW.

## Operation
Per-stage signals, where `v[k]` is the registered valid bit of stage k:
- **Source valid:** `src[0] = i_vld`, `src[k] = v[k-1]`.
- **Drain:** `drain[S-1] = i_rdy`, `drain[k] = en[k+1]`.
- **Hold:** `hold[k] = v[k] & ~drain[k]`.
- **Enable:** `en[k] = src[k] & ~hold[k] & i_rnd_vld & ~i_flush`. `o_stg_en = en`.

Valid-bit update:
- `v[k]` next state is 1 if `en[k]`.
- Otherwise it is 0 if `drain[k]` or `i_flush`.
- Otherwise it holds.

Output assignments:
- `o_vld = v[S-1]`. The downstream transfer is `v[S-1] & i_rdy`. The output stage drains without randomness.
- `o_rdy = ~hold[0] & i_rnd_vld & ~i_flush`.
- `o_rnd_take = |en`. All stages loading in one cycle share one randomness word.
- `o_busy = |v`.
- `o_cnt` increments on each downstream transfer, including during a flush cycle (the output word is still taken). It wraps from 2^CW−1 to 0.

Boundary conditions:
- **Flush:** all valid bits clear on the next edge, and no enable is asserted that cycle.
- **Full pipeline:** with `i_rdy=1` it still accepts one word per cycle (zero-bubble).
- **Randomness stall:** when `i_rnd_vld=0`, no stage loads. Occupied stages other than S-1 hold, and stage S-1 can still drain.
- **Reset mid-operation:** all valid bits and the counter clear asynchronously, and in-flight data is dropped.

## Timing
- **Reset values:** `o_rdy` follows its formula (1 only if `i_rnd_vld`); `o_vld` 0; `o_rnd_take` 0 unless `i_vld & i_rnd_vld`; `o_stg_en` per formula; `o_stg_vld` 0; `o_busy` 0; `o_cnt` 0.
- **Latency:** S cycles. A word accepted at edge t is presented with `o_vld=1` after edge t+S−1, provided there are no stalls.
- `o_rdy`, `o_stg_en` and `o_rnd_take` are combinational from `i_rdy`, `i_rnd_vld`, `i_flush` and `i_vld`. The ripple path runs through S stages and is accepted for S ≤ 8.
- All other outputs are registered.
- **Throughput:** 1 word/cycle.

## Structure
- Shared package `lix_pkg`: `LIX_STAGES` default (4) and `LIX_CNT_W` (16), used by the CSA top and this block.
- Valid bits need clear-on-drain, so they are plain flops, not `lix_reg`.
- One natural sub-module: `lix_stage_ctl`, a single-stage hold/enable/valid cell instantiated S times in a generate loop. The chain is wired through the `drain`/`src` signals.
- The counter lives in the top.

## Test plan
- **Basic flow, S=4:** reset, then assert `i_vld`, `i_rnd_vld`, `i_rdy` continuously → first `o_vld` 4 cycles after the first accept. Thereafter `o_vld` stays 1 every cycle, and `o_cnt` reaches 10 ten cycles after first `o_vld`.
- **Backpressure:** fill the pipe, then hold `i_rdy=0` → after 4 accepts `o_rdy=0`, `o_stg_vld=4'b1111`, `o_stg_en=0`. Release `i_rdy` → `o_rdy=1` in the same cycle with no bubble.
- **Randomness stall:** mid-stream, drop `i_rnd_vld` for 3 cycles → `o_stg_en=0` and `o_rnd_take=0` in all stages except the output drain, and `o_rdy=0`. Data order is preserved and latency extends by 3.
- **Flush:** with 3 stages occupied and `i_rdy=1`, pulse `i_flush` → `o_cnt` +1 for the output word only, `o_stg_vld=0` next cycle, and no enable asserted that cycle.
- **Counter wrap with CW=4:** 17 transfers → `o_cnt` returns to 1.
- **Async reset mid-stream:** assert `rst_ni=0` between edges → `o_vld`, `o_busy`, `o_stg_vld` and `o_cnt` read 0 immediately.
